// File: rtl/clkgen_pkg.sv
// Shared types and helpers for the clock-phase generator: FSM states,
// default divide-field width and a packed divide-vector field extractor.
package clkgen_pkg;

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    HALT = 2'd1,
    STEP = 2'd2
  } state_e;

  localparam int DEF_DIV_W = 4;
  localparam int MAX_DIV_W = 16;
  localparam int MAX_VEC_W = 256;

  // Field idx of width w from a zero-extended packed divide vector.
  function automatic logic [MAX_DIV_W-1:0] div_field(input logic [MAX_VEC_W-1:0] vec,
                                                     input int unsigned idx,
                                                     input int unsigned w);
    logic [MAX_VEC_W-1:0] sh;
    sh = vec >> (idx * w);
    return sh[MAX_DIV_W-1:0] & ((MAX_DIV_W'(1) << w) - MAX_DIV_W'(1));
  endfunction

endpackage

// File: rtl/clkgen_channel.sv
// One divided-clock channel: counter, phase bit, rise strobe and the
// active/pending divide registers. o_at_sync flags "about to rise".
module clkgen_channel #(
  parameter int               DIV_W = 4,
  parameter logic [DIV_W-1:0] INIT  = '0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             i_adv,
  input  logic             i_load,
  input  logic             i_apply,
  input  logic [DIV_W-1:0] i_div,
  output logic             o_clk,
  output logic             o_rise,
  output logic             o_at_sync
);

  logic [DIV_W-1:0] r_cnt, r_div, r_pend;
  logic             r_clk, r_rise;

  assign o_clk     = r_clk;
  assign o_rise    = r_rise;
  assign o_at_sync = (r_cnt == r_div) && !r_clk;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_cnt  <= INIT;
      r_div  <= INIT;
      r_pend <= INIT;
      r_clk  <= 1'b0;
      r_rise <= 1'b0;
    end else begin
      r_rise <= 1'b0;
      if (i_load) r_pend <= i_div;
      if (i_apply && i_adv) begin
        r_div  <= r_pend;
        r_cnt  <= '0;
        r_clk  <= 1'b1;
        r_rise <= 1'b1;
      end else if (i_apply) begin
        // Halted: park the new divider at its own sync point.
        r_div <= r_pend;
        r_cnt <= r_pend;
      end else if (i_adv) begin
        if (r_cnt == r_div) begin
          r_cnt  <= '0;
          r_clk  <= ~r_clk;
          r_rise <= ~r_clk;
        end else begin
          r_cnt <= r_cnt + DIV_W'(1);
        end
      end
    end
  end

endmodule

// File: rtl/clock_phase_gen.sv
// Multi-channel phase-aligned clock generator with run/halt control.
// Define CLKGEN_STEP_EN to add the single-hyperperiod STEP state.
module clock_phase_gen
  import clkgen_pkg::*;
#(
  parameter int                        NUM_CH   = 4,
  parameter int                        DIV_W    = DEF_DIV_W,
  parameter logic [NUM_CH*DIV_W-1:0]   INIT_DIV = {4'd3, 4'd1, 4'd1, 4'd0}
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [NUM_CH*DIV_W-1:0] div_in,
  input  logic                    div_load,
  input  logic                    run,
  input  logic                    step_req,
  output logic [NUM_CH-1:0]       ch_clk,
  output logic [NUM_CH-1:0]       ch_rise,
  output logic                    sync,
  output logic                    div_busy,
  output logic                    halted,
  output logic                    step_ack
);

  state_e                        r_state, w_state_nxt;
  logic                          w_adv, w_at_sync, w_apply;
  logic                          r_sync, r_busy;
  logic [NUM_CH-1:0]             w_ch_sync;
  logic [MAX_VEC_W-1:0]          w_div_vec;
  logic [NUM_CH-1:0][DIV_W-1:0]  w_div_f;

  assign w_div_vec = MAX_VEC_W'(div_in);
  assign w_at_sync = &w_ch_sync;
  // A load captured on this very edge must wait for the following sync point.
  assign w_apply   = r_busy && w_at_sync && !div_load;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    assign w_div_f[g] = DIV_W'(div_field(w_div_vec, g, DIV_W));
    clkgen_channel #(
      .DIV_W(DIV_W),
      .INIT (INIT_DIV[g*DIV_W +: DIV_W])
    ) u_ch (
      .clock    (clock),
      .reset    (reset),
      .i_adv    (w_adv),
      .i_load   (div_load),
      .i_apply  (w_apply),
      .i_div    (w_div_f[g]),
      .o_clk    (ch_clk[g]),
      .o_rise   (ch_rise[g]),
      .o_at_sync(w_ch_sync[g])
    );
  end

  always_comb begin
    w_state_nxt = r_state;
    w_adv       = 1'b0;
    case (r_state)
      RUN: begin
        w_adv = 1'b1;
        if (w_at_sync && !run) begin
          w_adv       = 1'b0;
          w_state_nxt = HALT;
        end
      end
      HALT: begin
        if (run) begin
          w_adv       = 1'b1;
          w_state_nxt = RUN;
        end
`ifdef CLKGEN_STEP_EN
        else if (step_req) begin
          w_adv       = 1'b1;
          w_state_nxt = STEP;
        end
`endif
      end
`ifdef CLKGEN_STEP_EN
      STEP: begin
        w_adv = 1'b1;
        if (w_at_sync) begin
          w_adv       = run;
          w_state_nxt = run ? RUN : HALT;
        end
      end
`endif
      default: w_state_nxt = RUN;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= RUN;
      r_sync  <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_sync  <= w_adv && w_at_sync;
      r_busy  <= div_load || (r_busy && !w_apply);
    end
  end

  assign sync     = r_sync;
  assign div_busy = r_busy;
  assign halted   = (r_state == HALT);

`ifdef CLKGEN_STEP_EN
  logic r_ack;
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) r_ack <= 1'b0;
    else        r_ack <= (r_state == STEP) && w_at_sync;
  end
  assign step_ack = r_ack;
`else
  logic w_unused_step;
  assign w_unused_step = step_req;
  assign step_ack      = 1'b0;
`endif

endmodule
